// File: rtl/copro_bus_arbiter.sv
// rtl/copro_bus_arbiter.sv - two-requester arbiter for Amiga bus mastership (BR/BG/BGACK handshake)
module copro_bus_arbiter #(
    parameter int TIMEOUT     = 255,
    parameter int ROUND_ROBIN = 1
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic BOSSn,
    input  logic req0_n,
    input  logic req1_n,
    input  logic a_BG_n,
    input  logic a_AS_n,
    input  logic a_BGACK_n,
    output logic gnt0_n,
    output logic gnt1_n,
    output logic br_oe,
    output logic bgack_oe,
    output logic owner,
    output logic busy,
    output logic timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_IDLE,
        S_OWN,
        S_RELEASE,
        S_BACKOFF
    } state_t;

    localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);
    localparam logic [7:0] BACKOFF_LAST = 8'd3;

    // bit order: {a_BG_n, a_AS_n, a_BGACK_n, req1_n, req0_n}
    logic [4:0] meta_d, meta_q;
    logic [4:0] sync_d, sync_q;

    state_t     state_d, state_q;
    logic [7:0] cnt_d, cnt_q;
    logic       owner_d, owner_q;
    logic       last_d, last_q;
    logic       gnt0_d, gnt0_q;
    logic       gnt1_d, gnt1_q;
    logic       br_d, br_q;
    logic       bgack_d, bgack_q;
    logic       busy_d, busy_q;
    logic       terr_d, terr_q;

    logic bg_s, as_s, bgack_s, req1_s, req0_s;
    logic win_req_n;
    logic tie_winner;

    assign bg_s    = sync_q[4];
    assign as_s    = sync_q[3];
    assign bgack_s = sync_q[2];
    assign req1_s  = sync_q[1];
    assign req0_s  = sync_q[0];

    assign win_req_n  = owner_q ? req1_s : req0_s;
    assign tie_winner = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;

    always_comb begin
        meta_d = {a_BG_n, a_AS_n, a_BGACK_n, req1_n, req0_n};
        sync_d = meta_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        br_d    = br_q;
        bgack_d = bgack_q;
        terr_d  = 1'b0;

        if (BOSSn) begin
            // Adapter does not own the Amiga side: drop everything, keep fairness history.
            state_d = S_IDLE;
            cnt_d   = 8'd0;
            gnt0_d  = 1'b1;
            gnt1_d  = 1'b1;
            br_d    = 1'b0;
            bgack_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!req0_s || !req1_s) begin
                        owner_d = (!req0_s && !req1_s) ? tie_winner : req0_s;
                        br_d    = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    cnt_d = cnt_q + 8'd1;
                    if (win_req_n) begin
                        br_d    = 1'b0;
                        state_d = S_IDLE;
                    end else if (!bg_s) begin
                        state_d = S_WAIT_IDLE;
                    end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
                        br_d    = 1'b0;
                        terr_d  = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = S_BACKOFF;
                    end
                end
                S_WAIT_IDLE: begin
                    // Take the bus only once the previous master has let AS and BGACK float high.
                    if (as_s && bgack_s) begin
                        bgack_d = 1'b1;
                        br_d    = 1'b0;
                        gnt0_d  = owner_q;
                        gnt1_d  = ~owner_q;
                        state_d = S_OWN;
                    end
                end
                S_OWN: begin
                    if (win_req_n) begin
                        gnt0_d  = 1'b1;
                        gnt1_d  = 1'b1;
                        state_d = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    bgack_d = 1'b0;
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end
                S_BACKOFF: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == BACKOFF_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    gnt0_d  = 1'b1;
                    gnt1_d  = 1'b1;
                    br_d    = 1'b0;
                    bgack_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            meta_q  <= 5'b11111;
            sync_q  <= 5'b11111;
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b1;
            gnt1_q  <= 1'b1;
            br_q    <= 1'b0;
            bgack_q <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            br_q    <= br_d;
            bgack_q <= bgack_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
        end
    end

    assign gnt0_n      = gnt0_q;
    assign gnt1_n      = gnt1_q;
    assign br_oe       = br_q;
    assign bgack_oe    = bgack_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: doc/copro_bus_arbiter.md
COPRO_BUS_ARBITER -- requirements
Module: copro_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles in REQ without bus grant before abort; range 1..255.
REQ-002 Parameter ROUND_ROBIN, default 1: 1 = last owner loses ties; 0 = requester 0 always wins.
REQ-003 CLK  in  1  system clock; the only clock; all flops on rising edge.
REQ-004 RESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 BOSSn  in  1  low = adapter owns the Amiga bus side; high = arbiter held idle.
REQ-006 req0_n, req1_n  in  1 each  requester bus requests, active-low, level, held for whole tenure.
REQ-007 gnt0_n, gnt1_n  out  1 each  grants, active-low, registered.
REQ-008 a_BG_n, a_AS_n, a_BGACK_n  in  1 each  Amiga bus grant, address strobe, grant-acknowledge (asynchronous).
REQ-009 br_oe  out  1  1 = pull Amiga BR low; 0 = release.
REQ-010 bgack_oe  out  1  1 = pull Amiga BGACK low; 0 = release.
REQ-011 owner  out  1  index of granted/selected requester; valid while busy=1.
REQ-012 busy  out  1  1 in any state except IDLE.
REQ-013 timeout_err  out  1  one-cycle pulse on grant timeout.

Function
REQ-014 a_BG_n, a_AS_n, a_BGACK_n, req0_n, req1_n each pass a 2-flop synchronizer; the FSM uses only synchronized values.
REQ-015 FSM states: IDLE, REQ, WAIT_IDLE, OWN, RELEASE, BACKOFF; all outputs registered.
REQ-016 IDLE: if BOSSn=0 and any synced req low -> latch winner into owner, set br_oe=1, clear counter, go REQ.
REQ-017 Arbitration: single request wins; simultaneous requests resolve per ROUND_ROBIN (RR: requester not equal to last owner; after reset last owner = 1, so requester 0 wins first tie).
REQ-018 Latency: raw req low before edge k -> br_oe=1 after edge k+2.
REQ-019 REQ: counter increments each cycle; synced a_BG_n=0 -> WAIT_IDLE (br_oe stays 1).
REQ-020 REQ: counter reaches TIMEOUT with no grant -> br_oe=0, timeout_err=1 for one cycle, go BACKOFF.
REQ-021 REQ: winner's synced req goes high -> br_oe=0, go IDLE, no grant issued.
REQ-022 BACKOFF: hold 4 cycles, all outputs released, then go IDLE.
REQ-023 WAIT_IDLE: when synced a_AS_n=1 and synced a_BGACK_n=1 on the same cycle -> bgack_oe=1, br_oe=0, winner's gnt_n=0, go OWN; all take effect on the same edge.
REQ-024 WAIT_IDLE: no timeout; waits for the bus to go idle indefinitely.
REQ-025 OWN: grant held while winner's synced req low; the other requester is never granted and there is no preemption.
REQ-026 OWN: winner's synced req high -> gnt_n=1, bgack_oe held 1, go RELEASE.
REQ-027 RELEASE: one cycle; then bgack_oe=0, record last owner, go IDLE.
REQ-028 A new request is not arbitrated until the edge after IDLE is entered.
REQ-029 At most one gnt_n is low at any time; gnt_n low implies bgack_oe=1.
REQ-030 br_oe and bgack_oe are never both 1 except during the WAIT_IDLE-to-OWN edge.
REQ-031 BOSSn=1 in any state -> next edge: IDLE, all outputs released, counter cleared, last owner unchanged.

Reset
REQ-032 RESETn=0 asynchronously forces IDLE, gnt0_n=gnt1_n=1, br_oe=0, bgack_oe=0, busy=0, owner=0, timeout_err=0, counter=0, last owner=1, synchronizers=1 (all signals idle-high).
REQ-033 Reset deasserted mid-tenure: no output reasserts until a fresh full handshake completes.

Verification
REQ-034 req0_n low, BG low 3 cycles after br_oe, AS/BGACK high -> br_oe=1 at k+2, then gnt0_n=0, bgack_oe=1, br_oe=0 on the same edge; req0_n high -> gnt0_n=1, bgack_oe=0 one cycle later.
REQ-035 req0_n and req1_n low on the same edge, ROUND_ROBIN=1 -> first tenure owner=0, second tenure owner=1; ROUND_ROBIN=0 -> owner=0 for both.
REQ-036 TIMEOUT=8, BG never asserted -> timeout_err pulses after 8 REQ cycles, br_oe=0, BACKOFF 4 cycles, request re-arbitrated.
REQ-037 BG low while a_AS_n held low 10 cycles -> stays in WAIT_IDLE with bgack_oe=0; grant issued 1 edge after synced AS high.
REQ-038 BOSSn raised during OWN -> next edge gnt0_n=1, bgack_oe=0, busy=0.
REQ-039 RESETn pulsed low during OWN -> all outputs idle immediately, with no clock edge required.
